// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
// The optional memory handshake is enabled with the ARM_MC_MEM_READY_EN macro.
package arm_ctrl_pkg;

    localparam int NUM_STATES = 10;
    localparam int STATE_W    = $clog2(NUM_STATES);
    localparam int FLAG_W     = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

endpackage

// File: rtl/arm_cond_logic.sv
// NZCV flag register (NZ and CV halves enabled separately) and the
// combinational condition evaluator that reads it.
module arm_cond_logic
    import arm_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        cond,
    input  logic [FLAG_W-1:0] alu_flags,
    input  logic              nz_write,
    input  logic              cv_write,
    output logic              cond_ex,
    output logic [FLAG_W-1:0] flags
);

    logic [1:0] nz;
    logic [1:0] cv;
    logic       n, z, c, v;

    always_ff @(posedge clk) begin
        if (reset) begin
            nz <= 2'b00;
        end else if (nz_write) begin
            nz <= alu_flags[3:2];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cv <= 2'b00;
        end else if (cv_write) begin
            cv <= alu_flags[1:0];
        end
    end

    assign flags = {nz, cv};
    assign {n, z} = nz;
    assign {c, v} = cv;

    // Reads the registered flags only, so a flag write lands one cycle later.
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: main FSM, ALU decode and condition-gated writes.
// Define ARM_MC_MEM_READY_EN to add the mem_ready wait handshake.
module arm_mc_controller
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic [3:0] alu_flags,
`ifdef ARM_MC_MEM_READY_EN
    input  logic       mem_ready,
`endif
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       adr_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic [1:0] reg_src,
    output logic [1:0] alu_control,
    output logic [3:0] state_dbg,
    output logic [3:0] flags_dbg
);

    state_t     state;
    logic       mem_ok;
    logic       cond_ex;
    logic [1:0] dec_alu;
    logic       cmd_ok;
    logic       ir_req, pc_req, branch_req, reg_req, mem_req, flag_req;
    logic       flag_ok;

`ifdef ARM_MC_MEM_READY_EN
    assign mem_ok = mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:  if (mem_ok) state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_MEM:  state <= S_MEMADR;
                        OP_DP:   state <= funct[5] ? S_EXECI : S_EXECR;
                        OP_BR:   state <= S_BRANCH;
                        default: state <= S_FETCH;
                    endcase
                end
                S_MEMADR: state <= funct[0] ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (mem_ok) state <= S_MEMWB;
                S_MEMWB:  state <= S_FETCH;
                S_MEMWR:  if (mem_ok) state <= S_FETCH;
                S_EXECR:  state <= S_ALUWB;
                S_EXECI:  state <= S_ALUWB;
                S_ALUWB:  state <= S_FETCH;
                S_BRANCH: state <= S_FETCH;
                default:  state <= S_FETCH;
            endcase
        end
    end

    // Unsupported commands still drive ADD but may not write a register or flags.
    always_comb begin
        dec_alu = ALU_ADD;
        cmd_ok  = 1'b1;
        case (funct[4:1])
            CMD_ADD: dec_alu = ALU_ADD;
            CMD_SUB: dec_alu = ALU_SUB;
            CMD_AND: dec_alu = ALU_AND;
            CMD_ORR: dec_alu = ALU_ORR;
            default: begin
                dec_alu = ALU_ADD;
                cmd_ok  = 1'b0;
            end
        endcase
    end

    always_comb begin
        ir_req      = 1'b0;
        pc_req      = 1'b0;
        branch_req  = 1'b0;
        reg_req     = 1'b0;
        mem_req     = 1'b0;
        flag_req    = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_RD2;
        result_src  = RES_ALUOUT;
        alu_control = ALU_ADD;
        case (state)
            S_FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_req     = mem_ok;
                pc_req     = mem_ok;
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
            end
            S_MEMADR: alu_src_b = SRCB_IMM;
            S_MEMRD:  adr_src = 1'b1;
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_req    = 1'b1;
            end
            S_MEMWR: begin
                adr_src = 1'b1;
                mem_req = mem_ok;
            end
            S_EXECR, S_EXECI: begin
                alu_src_b   = (state == S_EXECI) ? SRCB_IMM : SRCB_RD2;
                alu_control = dec_alu;
                flag_req    = funct[0] & cmd_ok;
            end
            S_ALUWB: reg_req = cmd_ok;
            S_BRANCH: begin
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALURESULT;
                branch_req = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are dropped while reset is high so an aborted instruction writes nothing.
    assign ir_write  = ~reset & ir_req;
    assign reg_write = ~reset & reg_req & cond_ex;
    assign mem_write = ~reset & mem_req & cond_ex;
    assign pc_write  = ~reset & (pc_req | ((branch_req | (reg_req & (rd == 4'b1111))) & cond_ex));
    assign flag_ok   = ~reset & flag_req & cond_ex;

    assign imm_src   = op;
    assign reg_src   = {op == OP_MEM, op == OP_BR};
    assign state_dbg = state;

    arm_cond_logic u_cond (
        .clk       (clk),
        .reset     (reset),
        .cond      (cond),
        .alu_flags (alu_flags),
        .nz_write  (flag_ok),
        .cv_write  (flag_ok & ((dec_alu == ALU_ADD) | (dec_alu == ALU_SUB))),
        .cond_ex   (cond_ex),
        .flags     (flags_dbg)
    );

endmodule

// File: doc/arm_mc_controller.md
Name: arm_mc_controller

Overview:
- Control unit for the multicycle ARM datapath.
- Sequences the datapath's enabled registers (PC, IR, register file, memory) through a main FSM.
- Decodes ALU operations and holds the NZCV condition flags.
- Gates all architectural writes with the condition check.

Parameters:
- NUM_STATES, 10, number of main-FSM states; fixed, sizes the state encoding.
- FLAG_W, 4, width of the NZCV flag register.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cond  in  4  Instr[31:28], condition field.
- op  in  2  Instr[27:26].
- funct  in  6  Instr[25:20]: I bit, cmd[3:0], S/L bit.
- rd  in  4  Instr[15:12].
- alu_flags  in  4  NZCV from the ALU, current cycle.
- pc_write  out  1  PC register enable.
- ir_write  out  1  instruction register enable.
- reg_write  out  1  register file write enable.
- mem_write  out  1  data memory write enable.
- adr_src  out  1  0 = PC, 1 = ALUOut.
- alu_src_a  out  1  0 = RD1, 1 = PC.
- alu_src_b  out  2  00 = RD2, 01 = ExtImm, 10 = constant 4.
- result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- imm_src  out  2  equals op.
- reg_src  out  2  [0] = (op==10), [1] = (op==01).
- alu_control  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR.

Behaviour:
- Reset (synchronous, active-high):
  - state <= FETCH; flags <= 0.
  - All outputs take their FETCH values on the cycle after reset deasserts.
  - Reset asserted mid-instruction aborts it; no write enable is asserted in the cycle reset is sampled high.
- States, with the outputs each one drives (unlisted enables = 0, unlisted selects = 0):
  - FETCH: adr_src=0, alu_src_a=1, alu_src_b=10, ADD, result_src=10, ir_write=1, pc_write=1.
  - DECODE: alu_src_a=1, alu_src_b=10, ADD, result_src=10.
  - MEMADR: alu_src_a=0, alu_src_b=01, ADD.
  - MEMRD: adr_src=1.
  - MEMWB: result_src=01, reg_write.
  - MEMWR: adr_src=1, mem_write.
  - EXECR: alu_src_b=00, ALU decode active.
  - EXECI: alu_src_b=01, ALU decode active.
  - ALUWB: result_src=00, reg_write.
  - BRANCH: alu_src_b=01, ADD, result_src=10, pc_write.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: op=01 -> MEMADR; op=00 with funct[5]=0 -> EXECR; op=00 with funct[5]=1 -> EXECI; op=10 -> BRANCH; op=11 -> FETCH with no writes.
  - MEMADR: funct[0]=1 -> MEMRD, else -> MEMWR.
  - MEMRD -> MEMWB -> FETCH.
  - MEMWR -> FETCH.
  - EXECR/EXECI -> ALUWB -> FETCH.
  - BRANCH -> FETCH.
- ALU decode (EXECR/EXECI only):
  - cmd 0100 -> ADD, 0010 -> SUB, 0000 -> AND, 1100 -> ORR.
  - Any other cmd -> ADD with reg_write and flag writes suppressed.
- Condition logic:
  - cond_ex is combinational from cond and the flags register.
  - Supported conditions: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL; cond 1111 -> cond_ex=0.
- Write gating:
  - reg_write and mem_write are the FSM requests ANDed with cond_ex.
  - Branch pc_write is also ANDed with cond_ex; the FETCH pc_write is unconditional.
  - A reg_write with rd=1111 additionally asserts pc_write (also gated).
- Flag update:
  - Only in EXECR/EXECI, only when funct[0]=1 and cond_ex=1.
  - ADD/SUB update all of NZCV; AND/ORR update NZ only and hold CV.
  - New flags are visible to cond_ex from the next cycle.
  - A same-cycle flag write and condition check uses the old flags.
- Instruction latency: data processing 4 cycles, load 5, store 4, branch 3.

Optional Feature:
- Macro: ARM_MC_MEM_READY_EN.
- When defined:
  - Adds input mem_ready (1 bit).
  - FETCH, MEMRD and MEMWR hold state while mem_ready=0, with ir_write, pc_write and mem_write forced to 0.
  - These enables assert only in the cycle mem_ready=1, and the FSM advances on that edge.
- When undefined: no port, memory assumed single-cycle, timing exactly as above.

Decomposition:
- Package arm_ctrl_pkg holds:
  - state enum (FETCH..BRANCH);
  - alu_control codes;
  - alu_src_b and result_src select codes;
  - cond code constants;
  - op codes (DP=00, MEM=01, BR=10).
- Sub-module arm_cond_logic: flags register (NZ and CV halves as separate enabled flops with synchronous reset) plus the cond_ex evaluator.
- The FSM and ALU decode remain in arm_mc_controller.

Test Plan:
- Reset held 3 cycles mid-MEMWR with op=01, funct[0]=0 -> mem_write=0 throughout; after release the state is FETCH, ir_write=1, pc_write=1, flags=0000.
- ADDS R1 (op=00, funct=001001, cond=1110), alu_flags=0110 -> 4-cycle sequence FETCH, DECODE, EXECR, ALUWB; flags=0110 after EXECR; reg_write=1 in ALUWB.
- Flags Z=1, then BNE (cond=0001, op=10) -> BRANCH with pc_write=0; BEQ (cond=0000) -> pc_write=1 in BRANCH.
- LDR (op=01, funct[0]=1) -> 5 cycles; adr_src=1 in MEMRD; result_src=01 with reg_write=1 in MEMWB. STR -> mem_write=1 only in MEMWR.
- ANDS with alu_flags=1011 over prior flags 0011 -> flags=1011 on NZ; CV holds at 11. ORR with rd=1111 in ALUWB -> reg_write=1 and pc_write=1.
- With ARM_MC_MEM_READY_EN: mem_ready=0 for 2 cycles in FETCH -> state holds, ir_write=0; on the ready cycle ir_write=1 and the next state is DECODE.
